delay_sum_beamformer: RTL and testbench
=======================================

DELAY_SUM_BEAMFORMER -- requirements
Module: delay_sum_beamformer

Interface
REQ-001 Parameters SHALL be, one per line:
  NCH, 4, number of receive channels.
  DATA_W, 32, signed sample width per channel.
  IDX_W, 16, sample index width.
  ADDR_W, 10, focal-point table address width (depth 2**ADDR_W).
  ACC_W, DATA_W+clog2(NCH), signed sum width.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all logic on rising edge.
  rst_n  in  1  asynchronous active-low reset.
  start  in  1  one-cycle pulse; begins a frame from IDLE.
  num_points  in  ADDR_W+1  focal points per frame; latched on accepted start.
  in_valid  in  1  sample beat valid.
  in_ready  out  1  beat accepted when in_valid && in_ready.
  in_index  in  IDX_W  sample index of beat; unsigned, non-decreasing within a frame.
  in_data  in  NCH*DATA_W  channel c sample at bits [c*DATA_W +: DATA_W].
  tbl_we  in  1  table write strobe.
  tbl_addr  in  ADDR_W  table write address.
  tbl_wdata  in  NCH*IDX_W  desired index per channel, same packing as in_data.
  out_valid  out  1  one-cycle result strobe.
  out_sum  out  ACC_W  delay-and-sum result.
  out_point  out  ADDR_W  focal point of result.
  out_miss  out  NCH  per-channel miss mask of result.
  busy  out  1  high whenever state is not IDLE.
  done  out  1  one-cycle end-of-frame pulse.

Function
REQ-003 Table SHALL be internal synchronous RAM, 2**ADDR_W x NCH*IDX_W, one-cycle read latency; contents not reset.
REQ-004 tbl_we SHALL write only in IDLE; writes in any other state ignored.
REQ-005 FSM states SHALL be IDLE, LOAD, RUN.
REQ-006 IDLE: start=1 with num_points>0 -> point=0, table read issued, LOAD; start with num_points=0 -> done pulse next cycle, remain IDLE; start outside IDLE ignored.
REQ-007 LOAD SHALL last exactly one cycle: capture table word into per-channel desired registers, clear accumulator, hit and miss flags, in_ready=0, -> RUN.
REQ-008 in_ready SHALL be 1 only in RUN; beats in IDLE/LOAD are not consumed.
REQ-009 RUN, per accepted beat, each unresolved channel c: in_index==D[c] -> add sign-extended sample c to accumulator, mark hit; in_index>D[c] (unsigned) -> mark miss, zero contribution; otherwise no change.
REQ-010 All channels SHALL be evaluated in parallel; several channels may resolve on one beat; resolved channels ignore later beats, including repeated indices.
REQ-011 When a beat leaves all NCH channels resolved, next cycle SHALL show out_valid=1 for one cycle with out_sum = total including that beat, out_point = current point, out_miss = miss flags.
REQ-012 At the resolving edge: point < num_points-1 -> point+1, table read, LOAD; else -> IDLE with done=1 in the same cycle as final out_valid.
REQ-013 Accumulation SHALL be signed two's complement at ACC_W bits; no overflow possible by construction.
REQ-014 out_sum, out_point, out_miss SHALL hold their values until the next out_valid.

Reset
REQ-015 rst_n=0 SHALL immediately force IDLE, in_ready=0, out_valid=0, out_sum=0, out_point=0, out_miss=0, busy=0, done=0, accumulator and flags cleared, regardless of state.
REQ-016 Reset mid-frame SHALL abandon the frame with no out_valid or done; table contents preserved; first start after release begins at point 0.

Verification (NCH=4, DATA_W=32, in_data all channels = in_index unless stated)
REQ-017 Point0 = {10,12,12,15}, num_points=1, stream indices 0..20 -> one out_valid the cycle after index-15 beat, out_sum=49, out_point=0, out_miss=0000, done with it.
REQ-018 Point0 = {5,5,5,5}, stream starts at index 8 -> out_valid after first beat, out_sum=0, out_miss=1111.
REQ-019 Three points {4,4,4,4},{6,7,8,9},{9,9,9,9}, num_points=3, in_valid held high -> out_sum 16, 30, 36 in order; in_ready low exactly one cycle after each of the first two resolutions; done only with third.
REQ-020 All channels data=-3, point0 = {2,2,2,2} -> out_sum=-12 (ACC_W=34, sign-extended).
REQ-021 rst_n low mid-RUN -> all outputs 0 asynchronously, no out_valid/done; rerun REQ-017 stimulus after release gives identical result.
REQ-022 tbl_we and start pulsed while busy -> table unchanged and frame unaffected, verified by readback via a subsequent frame.

Source files
------------

// File: rtl/delay_sum_beamformer.sv
// delay_sum_beamformer: per focal point, sums each channel's sample at its tabled index
// and flags channels whose index was skipped by the stream.
module delay_sum_beamformer #(
    parameter int NCH    = 4,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 16,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = DATA_W + $clog2(NCH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W:0]         num_points,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IDX_W-1:0]        in_index,
    input  logic [NCH*DATA_W-1:0]   in_data,
    input  logic                    tbl_we,
    input  logic [ADDR_W-1:0]       tbl_addr,
    input  logic [NCH*IDX_W-1:0]    tbl_wdata,
    output logic                    out_valid,
    output logic [ACC_W-1:0]        out_sum,
    output logic [ADDR_W-1:0]       out_point,
    output logic [NCH-1:0]          out_miss,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t state;
    logic [NCH*IDX_W-1:0] mem [2**ADDR_W];
    logic [NCH*IDX_W-1:0] rd_q;
    logic [ADDR_W-1:0] point, rd_addr;
    logic [ADDR_W:0] npts;
    logic [IDX_W-1:0] d [NCH];
    logic signed [ACC_W-1:0] acc, acc_n;
    logic [NCH-1:0] hit, miss, hit_n, miss_n;
    logic fire, resolved, last_pt;

    assign in_ready = state == RUN;
    assign busy     = state != IDLE;
    assign fire     = in_valid && in_ready;
    assign resolved = fire && &(hit_n | miss_n);
    assign last_pt  = {1'b0, point} + (ADDR_W+1)'(1) >= npts;
    // Address 0 is read while idle; during RUN the next point is prefetched for LOAD.
    assign rd_addr  = state == IDLE ? '0 : point + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (state == IDLE && tbl_we) mem[tbl_addr] <= tbl_wdata;
        rd_q <= mem[rd_addr];
    end

    always_comb begin
        acc_n  = acc;
        hit_n  = hit;
        miss_n = miss;
        for (int c = 0; c < NCH; c++)
            if (!hit[c] && !miss[c]) begin
                if (in_index == d[c]) begin
                    hit_n[c] = 1'b1;
                    acc_n    = acc_n + ACC_W'($signed(in_data[c*DATA_W +: DATA_W]));
                end else if (in_index > d[c]) miss_n[c] = 1'b1;
            end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            point     <= '0;
            npts      <= '0;
            acc       <= '0;
            hit       <= '0;
            miss      <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_point <= '0;
            out_miss  <= '0;
            done      <= 1'b0;
            for (int c = 0; c < NCH; c++) d[c] <= '0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    npts  <= num_points;
                    point <= '0;
                    if (num_points == '0) done <= 1'b1;
                    else state <= LOAD;
                end
                LOAD: begin
                    for (int c = 0; c < NCH; c++) d[c] <= rd_q[c*IDX_W +: IDX_W];
                    acc   <= '0;
                    hit   <= '0;
                    miss  <= '0;
                    state <= RUN;
                end
                RUN: if (fire) begin
                    acc  <= acc_n;
                    hit  <= hit_n;
                    miss <= miss_n;
                    if (resolved) begin
                        out_valid <= 1'b1;
                        out_sum   <= acc_n;
                        out_point <= point;
                        out_miss  <= miss_n;
                        if (last_pt) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            point <= rd_addr;
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_delay_sum_beamformer.sv
// tb_delay_sum_beamformer: directed frames with expected results queued at frame start.
module tb_delay_sum_beamformer;
    localparam int ACC_W = 34;
    logic clk = 0, rst_n = 1, start = 0, in_valid = 0, tbl_we = 0;
    logic [10:0] num_points = 0;
    logic [15:0] in_index = 0;
    logic [127:0] in_data = 0;
    logic [9:0] tbl_addr = 0;
    logic [63:0] tbl_wdata = 0;
    logic in_ready, out_valid, busy, done;
    logic [ACC_W-1:0] out_sum;
    logic [9:0] out_point;
    logic [3:0] out_miss;

    delay_sum_beamformer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_points(num_points),
        .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index), .in_data(in_data),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .out_valid(out_valid), .out_sum(out_sum), .out_point(out_point),
        .out_miss(out_miss), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [9:0] pt;
        logic [3:0] miss;
        logic last;
        int ridx;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0, last_idx = -1;
    logic lone_ok = 0, ready_next = 0;
    logic [ACC_W-1:0] held_sum = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        if (ready_next) begin
            chk("ready_after_load", 64'(in_ready), 1);
            ready_next = 0;
        end
        if (out_valid) begin
            if (q.size() == 0) chk("unexpected_valid", 64'(out_valid), 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", 64'(out_sum), 64'(e.sum));
                chk("point", 64'(out_point), 64'(e.pt));
                chk("miss", 64'(out_miss), 64'(e.miss));
                chk("done_with_last", 64'(done), 64'(e.last));
                chk("resolve_idx", 64'(last_idx), 64'(e.ridx));
                if (!e.last) begin
                    chk("ready_in_load", 64'(in_ready), 0);
                    ready_next = 1;
                end
            end
            held_sum = out_sum;
        end else begin
            if (done) chk("lone_done", 64'(done), 64'(lone_ok));
            chk("hold_sum", 64'(out_sum), 64'(held_sum));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic tbl_write(input int a, input logic [15:0] d0, d1, d2, d3);
        tbl_we = 1;
        tbl_addr = 10'(a);
        tbl_wdata = {d3, d2, d1, d0};
        tick();
        tbl_we = 0;
    endtask

    task automatic push(input logic [ACC_W-1:0] s, input int pt, input logic [3:0] m,
                        input logic l, input int r);
        exp_t e;
        e.sum = s; e.pt = 10'(pt); e.miss = m; e.last = l; e.ridx = r;
        q.push_back(e);
    endtask

    task automatic start_frame(input int n);
        start = 1;
        num_points = 11'(n);
        tick();
        start = 0;
    endtask

    // Beats advance only when accepted; the index saturates at 'last' and repeats.
    task automatic stream(input int first, input int last, input bit neg,
                          input int abort_after, input bit disturb);
        int idx = first;
        int n = 0;
        logic took;
        while (busy && n < 300 && (abort_after == 0 || n < abort_after)) begin
            in_valid = 1;
            in_index = 16'(idx);
            in_data = {4{(neg ? 32'hFFFF_FFFD : 32'(idx))}};
            tbl_we = disturb && n < 3;
            start = disturb && n < 3;
            tbl_addr = 0;
            tbl_wdata = {4{16'd20}};
            if (disturb) num_points = 11'd5;
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) last_idx = idx;
            monitor();
            if (took && idx < last) idx++;
            n++;
        end
        if (busy && abort_after == 0) chk("stream_timeout", 64'(busy), 0);
        in_valid = 0;
        tbl_we = 0;
        start = 0;
    endtask

    task automatic out_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 0);
        chk({tag, "_out_valid"}, 64'(out_valid), 0);
        chk({tag, "_out_sum"}, 64'(out_sum), 0);
        chk({tag, "_out_point"}, 64'(out_point), 0);
        chk({tag, "_out_miss"}, 64'(out_miss), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
    endtask

    initial begin
        #2 rst_n = 0;
        #1 out_zero("reset");
        tick();
        tick();
        @(negedge clk) rst_n = 1;

        tbl_write(0, 10, 12, 12, 15);
        push(49, 0, 4'b0000, 1, 15);
        start_frame(1);
        stream(0, 20, 0, 0, 0);
        tick();
        chk("q_empty_basic", 64'(q.size()), 0);

        tbl_write(0, 5, 5, 5, 5);
        push(0, 0, 4'b1111, 1, 8);
        start_frame(1);
        stream(8, 20, 0, 0, 0);
        tick();
        chk("q_empty_miss", 64'(q.size()), 0);

        tbl_write(0, 4, 4, 4, 4);
        tbl_write(1, 6, 7, 8, 9);
        tbl_write(2, 9, 9, 9, 9);
        push(16, 0, 4'b0000, 0, 4);
        push(30, 1, 4'b0000, 0, 9);
        push(36, 2, 4'b0000, 1, 9);
        start_frame(3);
        stream(0, 9, 0, 0, 0);
        tick();
        chk("q_empty_multi", 64'(q.size()), 0);

        tbl_write(0, 2, 2, 2, 2);
        push(-34'sd12, 0, 4'b0000, 1, 2);
        start_frame(1);
        stream(0, 10, 1, 0, 0);
        tick();
        chk("q_empty_neg", 64'(q.size()), 0);

        lone_ok = 1;
        start_frame(0);
        chk("zero_pts_done", 64'(done), 1);
        chk("zero_pts_busy", 64'(busy), 0);
        tick();
        chk("zero_pts_done_clear", 64'(done), 0);
        lone_ok = 0;

        tbl_write(0, 10, 12, 12, 15);
        start_frame(1);
        stream(0, 20, 0, 12, 0);
        chk("midrun_busy", 64'(busy), 1);
        #3 rst_n = 0;
        held_sum = 0;
        #1 out_zero("async_reset");
        tick();
        tick();
        @(negedge clk) rst_n = 1;
        push(49, 0, 4'b0000, 1, 15);
        start_frame(1);
        stream(0, 20, 0, 0, 0);
        tick();
        chk("q_empty_rerun", 64'(q.size()), 0);

        tbl_write(0, 1, 2, 3, 4);
        push(10, 0, 4'b0000, 1, 4);
        start_frame(1);
        stream(0, 20, 0, 0, 1);
        tick();
        push(10, 0, 4'b0000, 1, 4);
        start_frame(1);
        stream(0, 20, 0, 0, 0);
        tick();
        chk("q_empty_busy_writes", 64'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
